// File: rtl/result_credit_fifo.sv
// result_credit_fifo
// Credit-managed result buffer placed after a fixed-latency, non-stallable
// arithmetic stage. Upstream may launch an operation only while a credit is
// held, so every result that later emerges from the latency line is
// guaranteed a free slot here even if the consumer stalls.
//
// Handshakes: issue fires when issue_valid && issue_ready; output fires when
// out_valid && out_ready. out_valid/out_data stay stable while
// out_valid && !out_ready. in_valid has no back-pressure: the producer is the
// delayed valid of a pipeline that cannot stall.
module result_credit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_credits;
    logic             r_err;

    logic             w_issue_fire;
    logic             w_out_fire;
    logic             w_write;
    logic             w_drop;
    logic             w_issue_bad;
    logic [CW-1:0]    w_credits_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    // Handshake decode and output decode straight from registers
    always_comb begin
        issue_ready  = (r_credits != '0);
        out_valid    = (r_count != '0);
        out_data     = r_mem[r_rd_ptr];
        count        = r_count;
        err          = r_err;
        w_issue_fire = issue_valid && issue_ready;
        w_issue_bad  = issue_valid && !issue_ready;
        w_out_fire   = out_valid && out_ready;
        // A full buffer can still accept a write when a read frees a slot
        w_write      = in_valid && ((r_count != DEPTH_C) || w_out_fire);
        w_drop       = in_valid && (r_count == DEPTH_C) && !w_out_fire;
    end

    // Next-state arithmetic for credits, occupancy and wrapping pointers
    always_comb begin
        w_credits_nxt = r_credits;
        w_count_nxt   = r_count;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_rd_ptr_nxt  = r_rd_ptr;
        if (w_issue_fire && !w_out_fire) begin
            w_credits_nxt = r_credits - CW'(1);
        end else if (w_out_fire && !w_issue_fire && (r_credits != DEPTH_C)) begin
            // Saturate so an illegal injected result cannot mint extra credits
            w_credits_nxt = r_credits + CW'(1);
        end
        if (w_write && !w_out_fire) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_out_fire && !w_write) begin
            w_count_nxt = r_count - CW'(1);
        end
        if (w_write) begin
            w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
        end
        if (w_out_fire) begin
            w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
        end
    end

    // Control registers: credits, pointers, occupancy and sticky error
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_credits <= DEPTH_C;
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_credits <= w_credits_nxt;
            r_count   <= w_count_nxt;
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            if (w_issue_bad || w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    // Result storage, cleared on reset so out_data reads zero when empty
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_result_credit_fifo.sv
// tb_result_credit_fifo
// Drives result_credit_fifo through an emulated 4-deep latency line and
// checks it against a small reference model with an expected-result queue.
module tb_result_credit_fifo;

    localparam int W   = 32;
    localparam int D   = 8;
    localparam int CW  = 4;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [W-1:0]  issue_data = '0;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          err;

    // Direct injection onto in_valid, used only for protocol violations
    logic          inj_v = 1'b0;
    logic [W-1:0]  inj_d = '0;

    // Emulated upstream latency line (shares resetn with the DUT)
    logic [LAT-1:0] line_v;
    logic [W-1:0]   line_d [LAT];

    // Reference model state and scoreboard
    logic [W-1:0] exp_q [$];
    int m_credits = D;
    int m_count   = 0;
    logic m_err   = 1'b0;

    int checks = 0;
    int errors = 0;

    result_credit_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            line_v <= '0;
            for (int i = 0; i < LAT; i++) line_d[i] <= '0;
        end else begin
            line_v    <= {line_v[LAT-2:0], issue_valid && issue_ready};
            line_d[0] <= issue_data;
            for (int i = 1; i < LAT; i++) line_d[i] <= line_d[i-1];
        end
    end

    assign in_valid = line_v[LAT-1] | inj_v;
    assign in_data  = inj_v ? inj_d : line_d[LAT-1];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sampling: compare DUT against the model, then advance the
    // model to the state expected after the coming rising edge.
    task automatic scoreboard_monitor();
        logic         mo;
        logic         mi;
        logic         mw;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_credits = D;
                m_count   = 0;
                m_err     = 1'b0;
                exp_q.delete();
            end else begin
                checks++;
                if (issue_ready !== (m_credits != 0)) begin
                    errors++;
                    $display("FAIL sb_issue_ready: got %b expected %b at %0t", issue_ready, (m_credits != 0), $time);
                end
                checks++;
                if (out_valid !== (m_count != 0)) begin
                    errors++;
                    $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, (m_count != 0), $time);
                end
                checks++;
                if (count !== CW'(m_count)) begin
                    errors++;
                    $display("FAIL sb_count: got %0d expected %0d at %0t", count, m_count, $time);
                end
                checks++;
                if (err !== m_err) begin
                    errors++;
                    $display("FAIL sb_err: got %b expected %b at %0t", err, m_err, $time);
                end
                mo = (m_count != 0) && out_ready;
                mi = issue_valid && (m_credits != 0);
                mw = in_valid && ((m_count != D) || mo);
                if (mo) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_order: output fired with nothing expected at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            errors++;
                            $display("FAIL sb_data: got %0h expected %0h at %0t", out_data, e, $time);
                        end
                    end
                end
                if (issue_valid && (m_credits == 0)) m_err = 1'b1;
                if (in_valid && (m_count == D) && !mo) m_err = 1'b1;
                if (mi) exp_q.push_back(issue_data);
                if (mi && !mo) m_credits--;
                else if (mo && !mi && m_credits != D) m_credits++;
                if (mw && !mo) m_count++;
                else if (mo && !mw) m_count--;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready: got %b expected 1", issue_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (out_valid !== (i >= 5)) begin
                errors++;
                $display("FAIL stream_latency: cycle %0d got out_valid %b expected %b", i, out_valid, (i >= 5));
            end
            checks++;
            if (issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_throttle: cycle %0d got issue_ready %b expected 1", i, issue_ready);
            end
            issue_valid = 1'b1;
            issue_data  = W'(i);
        end
        cyc();
        issue_valid = 1'b0;
        repeat (8) cyc();
        checks++;
        if (count !== '0) begin errors++; $display("FAIL stream_drained: got count %0d expected 0", count); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_all_out: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure_fill();
        int accepted;
        accepted = 0;
        cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (issue_ready) begin
                issue_valid = 1'b1;
                issue_data  = W'(accepted);
                accepted++;
            end else begin
                issue_valid = 1'b0;
                break;
            end
        end
        issue_valid = 1'b0;
        checks++;
        if (accepted != D) begin errors++; $display("FAIL fill_accepted: got %0d expected %0d", accepted, D); end
        checks++;
        if (count !== CW'(4)) begin errors++; $display("FAIL fill_count_mid: got %0d expected 4", count); end
        for (int j = 1; j <= 4; j++) begin
            cyc();
            checks++;
            if (out_data !== '0) begin errors++; $display("FAIL fill_hold: cycle %0d got %0h expected 0", j, out_data); end
            checks++;
            if (issue_ready !== 1'b0) begin errors++; $display("FAIL fill_no_credit: got %b expected 0", issue_ready); end
        end
        checks++;
        if (count !== CW'(D)) begin errors++; $display("FAIL fill_count_full: got %0d expected %0d", count, D); end
    endtask

    task automatic test_drain_overlap();
        int n;
        n = 0;
        cyc();
        checks++;
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL drain_start: got issue_ready %b expected 0", issue_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++;
            if (dut.r_credits > 4'd1) begin
                errors++;
                $display("FAIL drain_credits: cycle %0d got %0d expected at most 1", k, dut.r_credits);
            end
            issue_valid = issue_ready;
            issue_data  = W'(200 + n);
            if (issue_ready) n++;
        end
        cyc();
        issue_valid = 1'b0;
        repeat (10) cyc();
        checks++;
        if (count !== '0) begin errors++; $display("FAIL drain_empty: got count %0d expected 0", count); end
        checks++;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL drain_credit_back: got %b expected 1", issue_ready); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL drain_all_out: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_violations();
        out_ready = 1'b0;
        for (int k = 0; k < D; k++) begin
            cyc();
            issue_valid = 1'b1;
            issue_data  = W'(300 + k);
        end
        cyc();
        issue_valid = 1'b0;
        repeat (5) cyc();
        checks++;
        if (count !== CW'(D)) begin errors++; $display("FAIL viol_full: got count %0d expected %0d", count, D); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL viol_err_clear: got %b expected 0", err); end
        issue_valid = 1'b1;
        issue_data  = 32'h0000_0999;
        cyc();
        issue_valid = 1'b0;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL viol_issue_err: got %b expected 1", err); end
        checks++;
        if (dut.r_credits !== 4'd0) begin errors++; $display("FAIL viol_issue_credits: got %0d expected 0", dut.r_credits); end
        inj_v = 1'b1;
        inj_d = 32'hDEAD_BEEF;
        cyc();
        inj_v = 1'b0;
        checks++;
        if (count !== CW'(D)) begin errors++; $display("FAIL viol_drop_count: got %0d expected %0d", count, D); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL viol_drop_err: got %b expected 1", err); end
        checks++;
        if (out_data !== 32'd300) begin errors++; $display("FAIL viol_drop_head: got %0h expected %0h", out_data, 32'd300); end
    endtask

    task automatic test_reset_midstream();
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            issue_valid = 1'b1;
            issue_data  = W'(400 + k);
        end
        cyc();
        issue_valid = 1'b0;
        cyc();
        cyc();
        checks++;
        if (count !== CW'(3)) begin errors++; $display("FAIL mid_count_pre: got %0d expected 3", count); end
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (count !== '0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (dut.r_credits !== 4'd8) begin errors++; $display("FAIL mid_credits: got %0d expected 8", dut.r_credits); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err); end
        cyc();
        cyc();
        resetn = 1'b1;
        repeat (6) cyc();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got out_valid %b expected 0", out_valid); end
        issue_valid = 1'b1;
        issue_data  = 32'h0000_0555;
        cyc();
        issue_valid = 1'b0;
        repeat (5) cyc();
        checks++;
        if (count !== CW'(1)) begin errors++; $display("FAIL mid_single_count: got %0d expected 1", count); end
        checks++;
        if (out_data !== 32'h0000_0555) begin errors++; $display("FAIL mid_single_data: got %0h expected 555", out_data); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_single_alone: got out_valid %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        fork
            scoreboard_monitor();
        join_none
        test_streaming();
        test_backpressure_fill();
        test_drain_overlap();
        test_violations();
        test_reset_midstream();
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
